// File: rtl/sigma_delta_adc_sequencer.sv
// sigma_delta_adc_sequencer
// Merges NUM_CH sigma-delta ADC channels into one valid/ready sample stream.
// Each channel has a one-deep capture register and a pending bit; a round-robin
// arbiter hands pending samples to a single registered output stage.
// Optional feature macro: SDADC_SEQ_OVERRUN_CNT_EN adds per-channel 8-bit
// saturating overrun counters on output overrun_cnt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | output stage empty; grant the next pending channel, if any
// PRESENT | out_valid high, payload frozen until the consumer takes it

module sigma_delta_adc_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int ADC_BITLEN = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [NUM_CH-1:0]            ch_rst,
    input  logic [NUM_CH*ADC_BITLEN-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_valid,
    output logic [ADC_BITLEN-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH-1:0]            overrun,
    input  logic [NUM_CH-1:0]            overrun_clr
`ifdef SDADC_SEQ_OVERRUN_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]          overrun_cnt
`endif
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         rr_q, rr_d;
    logic [ADC_BITLEN-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d;
    logic                    out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]       pend_q, pend_d;
    logic [NUM_CH-1:0]       overrun_q, overrun_d;
    logic [NUM_CH-1:0]       ch_rst_q;
    logic [ADC_BITLEN-1:0]   hold_q [NUM_CH];
    logic [ADC_BITLEN-1:0]   hold_d [NUM_CH];

    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       cap;
    logic [NUM_CH-1:0]       gnt_oh;
    logic [NUM_CH-1:0]       ov_set;
    logic                    gnt_vld;
    logic [CH_W-1:0]         gnt_idx;
    logic [CH_W:0]           rr_sum;
    logic                    grant_fire;

    // Round-robin search: first pending, still-enabled channel at/after rr_q.
    // A channel being disabled this cycle is not granted, so its sample is dropped.
    always_comb begin
        req     = pend_q & ch_enable;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rr_sum = {1'b0, rr_q} + (CH_W+1)'(k);
            if (rr_sum >= (CH_W+1)'(NUM_CH)) begin
                rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
            end
            if (!gnt_vld && req[rr_sum[CH_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_sum[CH_W-1:0];
            end
        end
    end

    // FSM next state and output-stage load/release.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        grant_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    grant_fire  = 1'b1;
                    out_data_d  = hold_q[gnt_idx];
                    out_ch_d    = gnt_idx;
                    out_valid_d = 1'b1;
                    rr_d        = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-channel capture, pending and overrun bookkeeping.
    // A fresh strobe on the channel being granted refills it without an overrun.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cap[i]    = ch_valid[i] & ch_enable[i];
            gnt_oh[i] = grant_fire && (gnt_idx == CH_W'(i));
            ov_set[i] = cap[i] & pend_q[i] & ~gnt_oh[i];
            hold_d[i] = cap[i] ? ch_data[i*ADC_BITLEN +: ADC_BITLEN] : hold_q[i];
            if (!ch_enable[i]) begin
                pend_d[i] = 1'b0;
            end else if (cap[i]) begin
                pend_d[i] = 1'b1;
            end else if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
            overrun_d[i] = ov_set[i] | (overrun_q[i] & ~overrun_clr[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and per-channel registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            pend_q      <= '0;
            overrun_q   <= '0;
            ch_rst_q    <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            ch_rst_q    <= ~ch_enable;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

`ifdef SDADC_SEQ_OVERRUN_CNT_EN
    logic [7:0] cnt_q [NUM_CH];
    logic [7:0] cnt_d [NUM_CH];

    // Saturating overrun counters; a set coinciding with a clear restarts at 1.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ov_set[i]) begin
                if (overrun_clr[i]) begin
                    cnt_d[i] = 8'd1;
                end else if (cnt_q[i] != 8'hFF) begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else if (overrun_clr[i]) begin
                cnt_d[i] = 8'd0;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        overrun_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            overrun_cnt[i*8 +: 8] = cnt_q[i];
        end
    end
`endif

    assign ch_rst    = ch_rst_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
